// File: rtl/eth_frame_gen.sv
// eth_frame_gen -- GMII transmit frame generator for link bring-up and loopback.
// Each frame is preamble, SFD, pattern payload, zero pad up to MIN_PAY, FCS, then an idle gap.
// Sends frame_cnt frames, or runs until stop when frame_cnt = 0.
//
// Ports
//   clk          GMII TX clock; everything runs on its rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse; accepted only in IDLE, latches every config input
//   stop         level or pulse; the current frame completes, then IDLE
//   frame_len    payload byte count, FCS excluded
//   frame_cnt    frames to send; 0 = continuous
//   ifg          idle cycles after each FCS; values below MIN_IFG are raised to MIN_IFG
//   mode         0/3 incrementing, 1 constant, 2 PRBS x^8+x^6+x^5+x^4+1
//   seed         pattern seed; a PRBS seed of 0 is replaced by 0x01
//   crc_err      inverts bit 0 of the last FCS byte of every frame
//   tx_clk       forwarded clk
//   tx_dat       GMII TXD, registered
//   tx_en        GMII TX_EN, registered
//   tx_er        tied low
//   busy         high from the cycle after start is accepted until IDLE is re-entered
//   done         one-cycle pulse on the cycle IDLE is re-entered
//   frames_sent  frames completed since the last start, saturating
module eth_frame_gen #(
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 16,
  parameter int PRE_LEN = 7,
  parameter int MIN_PAY = 60,
  parameter int MIN_IFG = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [CNT_W-1:0] frame_cnt,
  input  logic [7:0]       ifg,
  input  logic [1:0]       mode,
  input  logic [7:0]       seed,
  input  logic             crc_err,
  output logic             tx_clk,
  output logic [7:0]       tx_dat,
  output logic             tx_en,
  output logic             tx_er,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_sent
);

  // One extra bit so frame_len = all-ones never wraps the byte counter.
  localparam int CW = LEN_W + 1;
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] MIN_PAY_C = CW'(MIN_PAY);
  localparam logic [7:0]    MIN_IFG_C = 8'(MIN_IFG);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, GAP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             stop_q;
  logic             frame_end;
  logic [CNT_W-1:0] fs_next;

  logic [CW-1:0]    len_q;
  logic [CNT_W-1:0] fcnt_q;
  logic [7:0]       ifg_q;
  logic [1:0]       mode_q;
  logic [7:0]       seed_q;
  logic             err_q;
  logic [7:0]       pat_q;
  logic [31:0]      crc_q;

  logic [7:0]       dat_p0;
  logic             en_p0;
  logic [31:0]      fcs_word;

  // Reflected IEEE 802.3 CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] pat_step(input logic [7:0] p, input logic [1:0] m);
    case (m)
      2'd1:    pat_step = p;
      2'd2:    pat_step = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
      default: pat_step = p + 8'd1;
    endcase
  endfunction

  assign tx_clk   = clk;
  assign tx_er    = 1'b0;
  assign fcs_word = ~crc_q;
  assign fs_next  = (frames_sent == '1) ? frames_sent : frames_sent + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dat_p0    = 8'h00;
    en_p0     = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PRE;
          cnt_d   = '0;
        end
      end
      PRE: begin
        dat_p0 = 8'h55;
        en_p0  = 1'b1;
        if (cnt_q == PRE_LAST) begin
          state_d = SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SFD: begin
        dat_p0  = 8'hD5;
        en_p0   = 1'b1;
        cnt_d   = '0;
        state_d = (len_q == '0) ? PAD : DATA;
      end
      DATA: begin
        dat_p0 = pat_q;
        en_p0  = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_d == len_q) begin
          // Short payloads keep counting into PAD so the pad ends at MIN_PAY total bytes.
          if (len_q < MIN_PAY_C) begin
            state_d = PAD;
          end else begin
            state_d = FCS;
            cnt_d   = '0;
          end
        end
      end
      PAD: begin
        en_p0 = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_d >= MIN_PAY_C) begin
          state_d = FCS;
          cnt_d   = '0;
        end
      end
      FCS: begin
        en_p0  = 1'b1;
        dat_p0 = fcs_word[8*cnt_q[1:0] +: 8];
        if (cnt_q[1:0] == 2'd3) begin
          dat_p0[0] = fcs_word[24] ^ err_q;
          state_d   = GAP;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == CW'(ifg_q)) begin
          frame_end = 1'b1;
          cnt_d     = '0;
          if (stop_q || stop || ((fcnt_q != '0) && (fs_next == fcnt_q)))
            state_d = IDLE;
          else
            state_d = PRE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers: stage p0 -> GMII pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stop_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
      tx_dat      <= 8'h00;
      tx_en       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_dat  <= dat_p0;
      tx_en   <= en_p0;
      done    <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          busy        <= 1'b1;
          frames_sent <= '0;
          // A stop arriving with start still lets exactly one frame out.
          stop_q      <= stop;
        end
      end else begin
        stop_q <= stop_q | stop;
      end
      if (frame_end) begin
        frames_sent <= fs_next;
        if (state_d == IDLE) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Datapath: latched configuration, pattern generator and running CRC
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      len_q  <= {1'b0, frame_len};
      fcnt_q <= frame_cnt;
      ifg_q  <= (ifg < MIN_IFG_C) ? MIN_IFG_C : ifg;
      mode_q <= mode;
      seed_q <= seed;
      err_q  <= crc_err;
    end
    case (state_q)
      SFD: begin
        pat_q <= (mode_q == 2'd2 && seed_q == 8'h00) ? 8'h01 : seed_q;
        crc_q <= 32'hFFFF_FFFF;
      end
      DATA: begin
        pat_q <= pat_step(pat_q, mode_q);
        crc_q <= crc32_byte(crc_q, pat_q);
      end
      PAD: crc_q <= crc32_byte(crc_q, 8'h00);
      default: ;
    endcase
  end

endmodule
